// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot/run sequencer.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CPU_RST = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4
  } boot_state_t;

  // MIPS syscall encoding, used as the default end-of-program marker
  localparam logic [31:0] HALT_SYSCALL = 32'h0000_000C;

  localparam int CH_IMEM = 0;
  localparam int CH_DMEM = 1;
  localparam int CH_REG  = 2;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boot_cycle_timer.sv
// Loadable cycle counter: counts down toward zero or up toward a limit,
// flagging expiry combinationally from the registered count.
module boot_cycle_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         expired
);

  logic [W-1:0] count_r;

  // Count register; a load takes priority over counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en) begin
      count_r <= up ? (count_r + W'(1'b1)) : (count_r - W'(1'b1));
    end
  end

  assign count   = count_r;
  assign expired = up ? (count_r == limit) : (count_r == '0);

endmodule

// File: rtl/mips_boot_ctrl.sv
// Boot/run sequencer: streams loader words into CPU memories, pulses CPU reset,
// then runs a cycle-budgeted session. Optional BOOT_CHECKSUM_EN drives load_sum.
module mips_boot_ctrl
  import mips_boot_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 100,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_SYSCALL),
  localparam int CH_W = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [CH_W-1:0]   ld_ch,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic [NUM_CH-1:0] mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_resetn,
  input  logic [DATA_W-1:0] cpu_instr,
  input  logic              cpu_instr_vld,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              err_ch,
  output logic [31:0]       cycle_count,
  output logic [DATA_W-1:0] load_sum
);

  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(NUM_CH);

  boot_state_t state_r, state_nxt_s;

  logic              ld_ready_r, cpu_resetn_r, busy_r, done_r, timeout_r, err_ch_r;
  logic [NUM_CH-1:0] mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              accept_s, ch_ok_s, halt_s, start_ok_s, load_end_s;
  logic              rst_expired_s, run_expired_s;
  logic [31:0]       rst_count_unused_s, run_count_s;

  assign accept_s   = ld_ready_r & ld_valid;
  assign ch_ok_s    = ({1'b0, ld_ch} < CH_LIMIT);
  assign load_end_s = accept_s & ld_last;
  assign start_ok_s = start & ((state_r == IDLE) | (state_r == DONE));
  assign halt_s     = (state_r == RUN) & cpu_instr_vld & (cpu_instr == HALT_WORD);

  // Down-counter holds the CPU in reset for RST_CYCLES cycles after the load
  boot_cycle_timer #(.W(32)) u_rst_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_end_s),
    .load_val (32'(RST_CYCLES - 1)),
    .en       (state_r == CPU_RST),
    .up       (1'b0),
    .limit    (32'd0),
    .count    (rst_count_unused_s),
    .expired  (rst_expired_s)
  );

  // Up-counter is the run budget and doubles as cycle_count, frozen outside RUN
  boot_cycle_timer #(.W(32)) u_run_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (start_ok_s),
    .load_val (32'd0),
    .en       (state_r == RUN),
    .up       (1'b1),
    .limit    (32'(MAX_CYCLES - 1)),
    .count    (run_count_s),
    .expired  (run_expired_s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: if (start)                         state_nxt_s = LOAD;    else state_nxt_s = state_r;
      LOAD:       if (load_end_s)                    state_nxt_s = CPU_RST; else state_nxt_s = LOAD;
      CPU_RST:    if (rst_expired_s)                 state_nxt_s = RUN;     else state_nxt_s = CPU_RST;
      RUN:        if (halt_s || run_expired_s)       state_nxt_s = DONE;    else state_nxt_s = RUN;
      default:                                       state_nxt_s = IDLE;
    endcase
  end

  // Registered loader writes, status flags and CPU reset, all looking one state ahead
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_ready_r   <= 1'b0;
      cpu_resetn_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      timeout_r    <= 1'b0;
      err_ch_r     <= 1'b0;
      mem_we_r     <= '0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
    end else begin
      ld_ready_r   <= (state_nxt_s == LOAD);
      cpu_resetn_r <= (state_nxt_s == RUN);
      busy_r       <= (state_nxt_s == LOAD) || (state_nxt_s == CPU_RST) || (state_nxt_s == RUN);
      mem_we_r     <= (accept_s && ch_ok_s) ? (NUM_CH'(1'b1) << ld_ch) : '0;
      if (accept_s) begin
        mem_addr_r  <= ld_addr;
        mem_wdata_r <= ld_data;
      end
      if (start_ok_s) begin
        done_r    <= 1'b0;
        timeout_r <= 1'b0;
        err_ch_r  <= 1'b0;
      end else if ((state_r == RUN) && (state_nxt_s == DONE)) begin
        done_r    <= 1'b1;
        timeout_r <= ~halt_s;
      end
      if (accept_s && !ch_ok_s) err_ch_r <= 1'b1;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] load_sum_r;

  // Running sum of words actually written to a valid channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     load_sum_r <= '0;
    else if (start_ok_s)           load_sum_r <= '0;
    else if (accept_s && ch_ok_s)  load_sum_r <= load_sum_r + ld_data;
  end

  assign load_sum = load_sum_r;
`else
  assign load_sum = '0;
`endif

  assign ld_ready    = ld_ready_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign cpu_resetn  = cpu_resetn_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign timeout     = timeout_r;
  assign err_ch      = err_ch_r;
  assign cycle_count = run_count_s;

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Directed-sequence bench for mips_boot_ctrl with randomized loader/CPU traffic
// checked against a session-level reference model.
module tb_mips_boot_ctrl;
  import mips_boot_pkg::*;

  localparam int NUM_CH     = 3;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int RST_CYCLES = 2;
  localparam int MAX_CYCLES = 100;
  localparam logic [31:0] HALT = 32'h0000_000C;

  logic        clk = 1'b0;
  logic        reset, start, ld_valid, ld_ready, ld_last;
  logic [1:0]  ld_ch;
  logic [9:0]  ld_addr, mem_addr;
  logic [31:0] ld_data, mem_wdata, cpu_instr, cycle_count, load_sum;
  logic [2:0]  mem_we;
  logic        cpu_resetn, cpu_instr_vld, busy, done, timeout, err_ch;

  int compared   = 0;
  int mismatched = 0;

  int          w_ch   [16];
  logic [9:0]  w_addr [16];
  logic [31:0] w_data [16];
  logic [31:0] exp_sum;
  logic        exp_err;

  mips_boot_ctrl #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_ch(ld_ch), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_resetn(cpu_resetn), .cpu_instr(cpu_instr), .cpu_instr_vld(cpu_instr_vld),
    .busy(busy), .done(done), .timeout(timeout), .err_ch(err_ch),
    .cycle_count(cycle_count), .load_sum(load_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_sum();
`ifdef BOOT_CHECKSUM_EN
    return exp_sum;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_we"},      mem_we,      0);
    check({tag, "_addr"},    mem_addr,    0);
    check({tag, "_wdata"},   mem_wdata,   0);
    check({tag, "_ready"},   ld_ready,    0);
    check({tag, "_resetn"},  cpu_resetn,  0);
    check({tag, "_busy"},    busy,        0);
    check({tag, "_done"},    done,        0);
    check({tag, "_timeout"}, timeout,     0);
    check({tag, "_err"},     err_ch,      0);
    check({tag, "_count"},   cycle_count, 0);
    check({tag, "_sum"},     load_sum,    0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    exp_sum = 32'd0;
    exp_err = 1'b0;
    check("start_ready",   ld_ready,    1);
    check("start_busy",    busy,        1);
    check("start_done",    done,        0);
    check("start_timeout", timeout,     0);
    check("start_err",     err_ch,      0);
    check("start_count",   cycle_count, 0);
    check("start_sum",     load_sum,    0);
    check("start_resetn",  cpu_resetn,  0);
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 1);
      for (int g = 0; g < gap; g++) begin
        ld_valid = 1'b0;
        @(posedge clk); #1;
        check("we_idle", mem_we, 0);
      end
      check("ld_ready_on", ld_ready, 1);
      ld_valid = 1'b1;
      ld_ch    = 2'(w_ch[i]);
      ld_addr  = w_addr[i];
      ld_data  = w_data[i];
      ld_last  = (i == n - 1);
      @(posedge clk); #1;
      if (w_ch[i] < NUM_CH) begin
        check("we_onehot", mem_we, 3'b001 << w_ch[i]);
        check("wr_addr",   mem_addr,  w_addr[i]);
        check("wr_data",   mem_wdata, w_data[i]);
        exp_sum = exp_sum + w_data[i];
      end else begin
        check("we_dropped", mem_we, 0);
        exp_err = 1'b1;
      end
      check("err_ch",   err_ch,   exp_err);
      check("load_sum", load_sum, model_sum());
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("ld_ready_off", ld_ready, 0);
  endtask

  // h: RUN cycle carrying the halt word (-1 for none); inj: RUN cycle to pulse start
  task automatic run_session(input int h, input int inj);
    int zeros;
    logic [31:0] exp_cnt;
    logic        exp_to;
    zeros = 0;
    while (cpu_resetn !== 1'b1 && zeros < 20) begin
      zeros++;
      @(posedge clk); #1;
    end
    check("rst_cycles", zeros, RST_CYCLES);
    for (int c = 0; c < MAX_CYCLES + 5; c++) begin
      check("run_count", cycle_count, c);
      check("run_busy",  busy,        1);
      check("run_rstn",  cpu_resetn,  1);
      if (c == h) begin
        cpu_instr_vld = 1'b1;
        cpu_instr     = HALT;
      end else begin
        cpu_instr_vld = 1'($urandom_range(0, 1));
        if (cpu_instr_vld) cpu_instr = $urandom | 32'h100;
        else               cpu_instr = ($urandom_range(0, 1) == 1) ? HALT : $urandom;
      end
      start = (c == inj);
      @(posedge clk); #1;
      start = 1'b0;
      if (c == h || c == MAX_CYCLES - 1) break;
    end
    cpu_instr_vld = 1'b0;
    exp_to  = !(h >= 0 && h < MAX_CYCLES);
    exp_cnt = exp_to ? 32'(MAX_CYCLES) : 32'(h + 1);
    check("end_done",    done,        1);
    check("end_timeout", timeout,     exp_to);
    check("end_count",   cycle_count, exp_cnt);
    check("end_rstn",    cpu_resetn,  0);
    check("end_busy",    busy,        0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_done",  done,        1);
    check("hold_count", cycle_count, exp_cnt);
    check("hold_err",   err_ch,      exp_err);
    check("hold_sum",   load_sum,    model_sum());
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_ch = 2'd0; ld_addr = 10'd0; ld_data = 32'd0;
    cpu_instr = 32'd0; cpu_instr_vld = 1'b0;
    exp_sum = 32'd0; exp_err = 1'b0;
    #2;
    check_reset("por");
    #10 reset = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // Session A: 4 imem + 2 dmem words, halt on RUN cycle 7
    for (int i = 0; i < 6; i++) begin
      w_ch[i]   = (i < 4) ? CH_IMEM : CH_DMEM;
      w_addr[i] = 10'($urandom);
      w_data[i] = $urandom;
    end
    do_start();
    load_words(6);
    run_session(7, -1);

    // Session B: dropped words including the last one, budget runs out, start ignored in RUN
    for (int i = 0; i < 5; i++) begin
      w_ch[i]   = $urandom_range(0, 3);
      w_addr[i] = 10'($urandom);
      w_data[i] = $urandom;
    end
    w_ch[2] = 3;
    w_ch[4] = 3;
    do_start();
    load_words(5);
    run_session(-1, 10);

    // Session C: halt lands on the final budget cycle
    for (int i = 0; i < 3; i++) begin
      w_ch[i]   = (i == 0) ? CH_REG : $urandom_range(0, 2);
      w_addr[i] = 10'($urandom);
      w_data[i] = $urandom;
    end
    do_start();
    load_words(3);
    run_session(MAX_CYCLES - 1, -1);

    // Session D: asynchronous reset in the middle of a load
    do_start();
    ld_valid = 1'b1; ld_ch = 2'd0; ld_addr = 10'($urandom); ld_data = $urandom; ld_last = 1'b0;
    @(posedge clk); #1;
    check("midload_we", mem_we, 3'b001);
    #2 reset = 1'b1;
    #1;
    check_reset("midload_rst");
    ld_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy",  busy,     0);
    check("post_rst_ready", ld_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
